// File: rtl/vga_pkg.sv
// Shared VGA timing package.
// Holds the default 640x480@60 timing constants, the derived line/frame
// totals, the sync-window bounds for the defaults, and the colour type.
package vga_pkg;

  localparam int H_DISP_D = 640;
  localparam int H_FP_D   = 16;
  localparam int H_SYNC_D = 96;
  localparam int H_BP_D   = 48;
  localparam int V_DISP_D = 480;
  localparam int V_FP_D   = 10;
  localparam int V_SYNC_D = 2;
  localparam int V_BP_D   = 33;
  localparam int PIX_DIV_D = 2;

  localparam int H_TOTAL_D = H_DISP_D + H_FP_D + H_SYNC_D + H_BP_D;  // 800
  localparam int V_TOTAL_D = V_DISP_D + V_FP_D + V_SYNC_D + V_BP_D;  // 525

  // Sync pulse windows (inclusive) for the default timing
  localparam int H_SYNC_START_D = H_DISP_D + H_FP_D;                 // 656
  localparam int H_SYNC_END_D   = H_DISP_D + H_FP_D + H_SYNC_D - 1;  // 751
  localparam int V_SYNC_START_D = V_DISP_D + V_FP_D;                 // 490
  localparam int V_SYNC_END_D   = V_DISP_D + V_FP_D + V_SYNC_D - 1;  // 491

  typedef logic [2:0] rgb_t;

  // Sum of the four segments of a line or frame, as a 10-bit count
  function automatic logic [9:0] seg_total(input int disp, input int fp,
                                           input int syn, input int bp);
    return 10'(disp + fp + syn + bp);
  endfunction

endpackage

// File: rtl/pix_div.sv
// Pixel clock-enable divider.
// Counts 0..PIX_DIV-1 on every clk and raises pix_tick_o on the last count.
// With PIX_DIV=1 the counter is stuck at 0 and pix_tick_o is always high.
// Ports:
//   clk_i       system clock
//   rst_ni      synchronous active-low reset
//   pix_tick_o  one-clk pixel enable
module pix_div #(
  parameter int PIX_DIV = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic pix_tick_o
);

  localparam logic [3:0] DIV_LAST = 4'(PIX_DIV - 1);

  logic [3:0] div_q, div_d;

  always_comb begin
    div_d = (div_q == DIV_LAST) ? 4'd0 : div_q + 4'd1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) div_q <= 4'd0;
    else         div_q <= div_d;
  end

  assign pix_tick_o = (div_q == DIV_LAST);

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster generator.
// Produces the pixel enable, x/y raster counters, active-video flag and the
// once-per-frame tick; blanks the pixel generator's colour outside the
// active area and registers it with hsync/vsync one pixel after x/y.
// Optional feature macro: VGA_SYNC_FRAME_CNT_EN builds an 8-bit frame counter;
// without it frame_cnt is tied to zero.
// Ports:
//   clk, rst (sync, active-low), rgb_in  -- clock, reset, pixel colour in
//   x, y, video_on, pix_tick, frame_tick -- raster state and enables
//   hsync, vsync, rgb_out                -- registered outputs to the DAC
//   frame_cnt                            -- frame counter (or 0)
module vga_sync_gen
  import vga_pkg::*;
#(
  parameter int H_DISP  = H_DISP_D,
  parameter int H_FP    = H_FP_D,
  parameter int H_SYNC  = H_SYNC_D,
  parameter int H_BP    = H_BP_D,
  parameter int V_DISP  = V_DISP_D,
  parameter int V_FP    = V_FP_D,
  parameter int V_SYNC  = V_SYNC_D,
  parameter int V_BP    = V_BP_D,
  parameter int PIX_DIV = PIX_DIV_D
) (
  input  logic       clk,
  input  logic       rst,
  input  rgb_t       rgb_in,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       video_on,
  output logic       pix_tick,
  output logic       frame_tick,
  output logic       hsync,
  output logic       vsync,
  output rgb_t       rgb_out,
  output logic [7:0] frame_cnt
);

  localparam logic [9:0] H_LAST   = seg_total(H_DISP, H_FP, H_SYNC, H_BP) - 10'd1;
  localparam logic [9:0] V_LAST   = seg_total(V_DISP, V_FP, V_SYNC, V_BP) - 10'd1;
  localparam logic [9:0] H_ACT    = 10'(H_DISP);
  localparam logic [9:0] V_ACT    = 10'(V_DISP);
  localparam logic [9:0] HS_START = 10'(H_DISP + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_DISP + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_START = 10'(V_DISP + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_DISP + V_FP + V_SYNC - 1);

  pix_div #(.PIX_DIV(PIX_DIV)) u_pix_div (
    .clk_i      (clk),
    .rst_ni     (rst),
    .pix_tick_o (pix_tick)
  );

  // Stage 0: raster counters
  logic [9:0] x_q, x_d, y_q, y_d;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (pix_tick) begin
      if (x_q == H_LAST) begin
        // line wrap and frame wrap resolve on the same edge
        x_d = 10'd0;
        y_d = (y_q == V_LAST) ? 10'd0 : y_q + 10'd1;
      end else begin
        x_d = x_q + 10'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      x_q <= 10'd0;
      y_q <= 10'd0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x          = x_q;
  assign y          = y_q;
  assign video_on   = (x_q < H_ACT) && (y_q < V_ACT);
  assign frame_tick = pix_tick && (x_q == H_LAST) && (y_q == V_LAST);

  // Stage 1: sync decode and blanking, one pixel behind x/y
  logic hsync_q, hsync_d, vsync_q, vsync_d;
  rgb_t rgb_q, rgb_d;

  always_comb begin
    hsync_d = !((x_q >= HS_START) && (x_q <= HS_END));
    vsync_d = !((y_q >= VS_START) && (y_q <= VS_END));
    rgb_d   = video_on ? rgb_in : 3'd0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      rgb_q   <= 3'd0;
    end else if (pix_tick) begin
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      rgb_q   <= rgb_d;
    end
  end

  assign hsync   = hsync_q;
  assign vsync   = vsync_q;
  assign rgb_out = rgb_q;

`ifdef VGA_SYNC_FRAME_CNT_EN
  logic [7:0] fcnt_q;

  always_ff @(posedge clk) begin
    if (!rst)            fcnt_q <= 8'd0;
    else if (frame_tick) fcnt_q <= fcnt_q + 8'd1;
  end

  assign frame_cnt = fcnt_q;
`else
  assign frame_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen using a shrunken raster so whole frames
// fit in a short run: 8+2+3+2 = 15 pixels/line, 4+1+2+1 = 8 lines/frame,
// PIX_DIV=2 -> 240 clks per frame. hsync window x=10..12, vsync y=5..6.
module tb_vga_sync_gen;
  import vga_pkg::*;

  localparam int FRAME_CLKS = 15 * 8 * 2;
`ifdef VGA_SYNC_FRAME_CNT_EN
  localparam bit FC_EN = 1'b1;
`else
  localparam bit FC_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  rgb_t       rgb_in;
  logic [9:0] x, y;
  logic       video_on, pix_tick, frame_tick, hsync, vsync;
  rgb_t       rgb_out;
  logic [7:0] frame_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vga_sync_gen #(
    .H_DISP(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_DISP(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .PIX_DIV(2)
  ) dut (
    .clk(clk), .rst(rst), .rgb_in(rgb_in),
    .x(x), .y(y), .video_on(video_on), .pix_tick(pix_tick),
    .frame_tick(frame_tick), .hsync(hsync), .vsync(vsync),
    .rgb_out(rgb_out), .frame_cnt(frame_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance n clk edges, sampling/driving 1 time unit after each edge
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Bounded wait for the pix_tick sample at pixel (wx, wy)
  task automatic wait_xy(input logic [9:0] wx, input logic [9:0] wy);
    bit found = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (x == wx && y == wy && pix_tick) begin
        found = 1'b1;
        break;
      end
      step(1);
    end
    if (!found) check("wait_xy_timeout", 32'd0, 32'd1);
  endtask

  int lit, hlow, vlow, ftick, n;

  initial begin
    rst    = 1'b0;
    rgb_in = 3'b111;
    step(5);
    // Reset state
    check("rst_x", x, 0);
    check("rst_y", y, 0);
    check("rst_hsync", hsync, 1);
    check("rst_vsync", vsync, 1);
    check("rst_rgb", rgb_out, 0);
    check("rst_fcnt", frame_cnt, 0);
    check("rst_video_on", video_on, 1);
    check("rst_pix_tick", pix_tick, 0);
    check("rst_frame_tick", frame_tick, 0);

    // Release: first pix_tick one clk later
    rst = 1'b1;
    check("rel_pix_tick0", pix_tick, 0);
    step(1);
    check("rel_pix_tick1", pix_tick, 1);
    check("rel_x0", x, 0);
    step(1);
    check("rel_pix_tick2", pix_tick, 0);
    check("rel_x1", x, 1);
    check("rel_rgb_px0", rgb_out, 3'b111);

    // Blanking edge: last active pixel still lit, first porch pixel blank
    wait_xy(10'd8, 10'd0);
    check("blank_px7", rgb_out, 3'b111);
    step(1);
    check("blank_px8", rgb_out, 0);

    // hsync goes low one pixel after x reaches the window start
    wait_xy(10'd10, 10'd0);
    check("hs_before", hsync, 1);
    step(1);
    check("hs_low", hsync, 0);
    check("hs_x11", x, 11);

    // Line wrap: x 14->0 and y 0->1 on the same edge
    wait_xy(10'd14, 10'd0);
    check("lw_ft", frame_tick, 0);
    step(1);
    check("lw_x", x, 0);
    check("lw_y", y, 1);

    // Frame wrap
    wait_xy(10'd14, 10'd7);
    check("fw_ft", frame_tick, 1);
    step(1);
    check("fw_x", x, 0);
    check("fw_y", y, 0);
    check("fw_ft_single", frame_tick, 0);

    // One full frame of outputs, sampled once per pixel
    lit = 0; hlow = 0; vlow = 0; ftick = 0;
    for (int i = 0; i < FRAME_CLKS; i++) begin
      step(1);
      if (frame_tick) begin
        ftick++;
        check("ft_pos_x", x, 14);
        check("ft_pos_y", y, 7);
      end
      if (pix_tick) begin
        if (rgb_out == 3'b111) lit++;
        if (!hsync) hlow++;
        if (!vsync) vlow++;
      end
    end
    check("frame_lit", lit, 32);
    check("frame_hlow", hlow, 24);
    check("frame_vlow", vlow, 30);
    check("frame_ticks", ftick, 1);

    // Mid-frame reset for one clk
    wait_xy(10'd6, 10'd3);
    rst = 1'b0;
    n = 0;
    step(1); n++;
    check("mr_x", x, 0);
    check("mr_y", y, 0);
    check("mr_pix_tick", pix_tick, 0);
    check("mr_hsync", hsync, 1);
    check("mr_rgb", rgb_out, 0);
    check("mr_fcnt", frame_cnt, 0);
    rst = 1'b1;
    while (!frame_tick && n < 1000) begin
      step(1); n++;
    end
    check("mr_first_ft", n, FRAME_CLKS);
    n = 0;
    step(1); n++;
    while (!frame_tick && n < 1000) begin
      step(1); n++;
    end
    check("ft_period", n, FRAME_CLKS);

    // Frame counter over 257 frames
    rst = 1'b0;
    step(1);
    rst = 1'b1;
    step(255 * FRAME_CLKS);
    check("fcnt_255", frame_cnt, FC_EN ? 255 : 0);
    step(FRAME_CLKS);
    check("fcnt_256", frame_cnt, 0);
    step(FRAME_CLKS);
    check("fcnt_257", frame_cnt, FC_EN ? 1 : 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

- Generates the VGA raster for the display path: a pixel-rate enable, horizontal and vertical position counters, and the sync pulses.
- Drives the `x`/`y` coordinates consumed by the graphics/text pixel generator.
- Takes that generator's `rgb` back, blanks it outside the active area, and registers it together with `hsync`/`vsync` toward the DAC pins.
- Its `frame_tick` is the once-per-frame event used for game-object updates.

## Interface
Parameters:
- `H_DISP`, 640: active pixels per line
- `H_FP`, 16: horizontal front porch
- `H_SYNC`, 96: hsync pulse width
- `H_BP`, 48: horizontal back porch
- `V_DISP`, 480: active lines
- `V_FP`, 10: vertical front porch
- `V_SYNC`, 2: vsync pulse width
- `V_BP`, 33: vertical back porch
- `PIX_DIV`, 2: clk cycles per pixel, 1..16

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  reset; synchronous, active-low
- `rgb_in`  in  3  pixel colour from the pixel generator for the current `x`/`y`
- `x`  out  10  current horizontal count, 0..H_TOTAL-1
- `y`  out  10  current vertical count, 0..V_TOTAL-1
- `video_on`  out  1  high when `x<H_DISP && y<V_DISP`
- `pix_tick`  out  1  one-clk pixel enable
- `frame_tick`  out  1  one-clk pulse at the last pixel of a frame
- `hsync`  out  1  active-low horizontal sync, aligned with `rgb_out`
- `vsync`  out  1  active-low vertical sync, aligned with `rgb_out`
- `rgb_out`  out  3  blanked, registered colour to the DAC
- `frame_cnt`  out  8  frame counter; see Configuration

## Operation
- Totals:
  - H_TOTAL = H_DISP+H_FP+H_SYNC+H_BP (800).
  - V_TOTAL = V_DISP+V_FP+V_SYNC+V_BP (525).
- Divider:
  - `div` counts 0..PIX_DIV-1 every clk and wraps.
  - `pix_tick = (div==PIX_DIV-1)`.
  - With PIX_DIV=1, `pix_tick` is constantly 1 out of reset.
- Counters:
  - On a clk edge with `pix_tick`=1, `x` increments.
  - At H_TOTAL-1, `x` wraps to 0 and `y` increments.
  - At V_TOTAL-1 together with `x` at H_TOTAL-1, `y` wraps to 0.
  - All arithmetic is 10-bit unsigned; the counters never exceed their totals.
- Stage 0 (x, y, video_on) is the counter state itself.
- Stage 1 (hsync, vsync, rgb_out) is registered on `pix_tick` from stage 0:
  - `hsync`=0 when `x` is in [H_DISP+H_FP, H_DISP+H_FP+H_SYNC-1] (656..751).
  - `vsync`=0 when `y` is in [V_DISP+V_FP, V_DISP+V_FP+V_SYNC-1] (490..491).
  - `rgb_out` = `video_on` ? `rgb_in` : 0.
- `frame_tick = pix_tick && x==H_TOTAL-1 && y==V_TOTAL-1`.
- Reset (`rst`=0 sampled at a clk edge):
  - `div`, `x`, `y` = 0; `video_on`=1.
  - `hsync`=1, `vsync`=1, `rgb_out`=0, `frame_cnt`=0.
  - `pix_tick`=0 when PIX_DIV>1.
  - `frame_tick`=0.
- Reset applies mid-line or mid-frame with no restriction. The next frame starts at (0,0) with `div`=0.

## Timing
- Latency from `x`/`y` to `rgb_out`/`hsync`/`vsync` is exactly one pixel period (PIX_DIV clks).
- `rgb_in` is sampled on the clk edge where `pix_tick`=1. It must be valid by the last clk of the pixel period.
- After reset release, the first `pix_tick` occurs in clk cycle PIX_DIV-1.
- Line period: H_TOTAL×PIX_DIV clks. Frame period: H_TOTAL×V_TOTAL×PIX_DIV clks (840000 at defaults).
- `frame_tick` and `pix_tick` are single-clk pulses and are never stretched.
- Line wrap and frame wrap on the same pixel both take effect in the same clk edge.

## Configuration
- Macro: `VGA_SYNC_FRAME_CNT_EN`.
- Defined:
  - `frame_cnt` increments by 1 on every `frame_tick`.
  - It wraps 255→0 and clears on reset.
- Undefined:
  - No counter logic is built.
  - `frame_cnt` is tied to 8'd0.
  - All other behaviour is identical.

## Structure
- Shared package `vga_pkg`:
  - default timing constants (H_DISP..V_BP)
  - derived H_TOTAL/V_TOTAL
  - sync-window bounds
  - a 3-bit `rgb_t` typedef
- One sub-module, `pix_div`: the parameterised clock-enable divider producing `pix_tick`.
- Counters, decode and output stage live in the top.

## Test plan
- Reset: hold `rst`=0 for 5 clks. Expect `x`=0, `y`=0, `hsync`=1, `vsync`=1, `rgb_out`=0, `frame_cnt`=0; first `pix_tick` 1 clk after release (PIX_DIV=2).
- Line wrap: run 1600 clks. `x` goes 799→0 while `y` goes 0→1 on the same edge. `hsync` is low for exactly 96 pixels, first low pixel one pixel after `x`=656.
- Frame:
  - `vsync` is low for exactly 2 lines (y 490..491, delayed one pixel).
  - `frame_tick` pulses once every 840000 clks at `x`=799, `y`=524.
- Blanking: hold `rgb_in`=3'b111. `rgb_out`=3'b111 only for pixels with x<640 and y<480; otherwise 0; 307200 lit pixels per frame.
- Mid-frame reset: assert `rst` at `x`=300, `y`=200 for 1 clk. Counters restart at (0,0) and the next `frame_tick` follows exactly 840000 clks later.
- Macro: with `VGA_SYNC_FRAME_CNT_EN`, 257 frames give `frame_cnt`=1 after wrapping 255→0. Without the macro, `frame_cnt` stays 0.
